// File: rtl/cmd_pkg.sv
// cmd_pkg: definitions shared by cmd_dispatcher and cmd_fifo.
//   - Command field positions (opcode byte, payload, unit-select bits).
//   - Dispatcher FSM state encoding.
//   - Opcode class check used by the decoder.
package cmd_pkg;

  localparam int unsigned OPC_MSB   = 63;
  localparam int unsigned OPC_LSB   = 56;
  localparam int unsigned PAYLOAD_W = 56;
  localparam int unsigned CMD_W     = 64;
  localparam int unsigned SEL_MSB   = 1;
  localparam int unsigned SEL_LSB   = 0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DECODE   = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_e;

  // An opcode belongs to the legal class when its upper nibble matches the mask.
  function automatic logic opc_class_ok(input logic [7:0] opc, input logic [7:0] mask);
    return opc[7:4] == mask[7:4];
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO with a registered read port.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   push, din : write request and data (ignored when full unless popping)
//   pop       : read request; dout updates on the edge that accepts it
//   dout      : registered head data
//   full/empty/level : occupancy status
module cmd_fifo
  import cmd_pkg::*;
#(
  parameter int unsigned WIDTH = CMD_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] dout_q;
  logic             do_push, do_pop;

  // Extra pointer bit lets full and empty be told apart with a plain subtract.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full queue is still taken.
  assign do_push = push && (!full || do_pop);
  assign dout    = dout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      dout_q   <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= din;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        dout_q   <= mem_q[rd_ptr_q[AW-1:0]];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: captures commands from the parallel receiver on each rising
// edge of cmd_ready, queues them, decodes the opcode and hands the payload to
// one execution unit over a valid/ack handshake, one command at a time.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   cmd_in        : assembled command {opcode[7:0], payload[55:0]}
//   cmd_ready     : receiver ready level; one capture per rising edge
//   unit_valid    : one-hot request to the selected unit
//   unit_payload  : payload of the in-flight command
//   unit_ack      : per-unit accept; only the selected bit counts
//   fifo_level    : queue occupancy
//   overflow      : sticky, capture lost to a full queue
//   bad_opcode    : sticky, illegal opcode dropped
//   idle          : queue empty and FSM idle
//   ack_timeout   : sticky, ack watchdog expired (only with CMD_DISPATCH_TIMEOUT_EN)
// Build option: `define CMD_DISPATCH_TIMEOUT_EN adds the ack watchdog.
module cmd_dispatcher
  import cmd_pkg::*;
#(
  parameter int unsigned NUM_UNITS      = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter logic [7:0]  OPC_VALID_MASK = 8'hF0,
  parameter int unsigned TIMEOUT        = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CMD_W-1:0]              cmd_in,
  input  logic                          cmd_ready,
  output logic [NUM_UNITS-1:0]          unit_valid,
  output logic [PAYLOAD_W-1:0]          unit_payload,
  input  logic [NUM_UNITS-1:0]          unit_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          bad_opcode,
  output logic                          idle
`ifdef CMD_DISPATCH_TIMEOUT_EN
  ,
  output logic                          ack_timeout
`endif
);

  state_e                 state_q, state_d;
  logic                   cmd_ready_q;
  logic                   capture;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0]       head;
  logic [7:0]             opc;
  logic [SEL_MSB:SEL_LSB] sel;
  logic [NUM_UNITS-1:0]   unit_valid_q, unit_valid_d;
  logic [PAYLOAD_W-1:0]   payload_q, payload_d;
  logic                   overflow_q, overflow_d;
  logic                   bad_q, bad_d;
  logic                   acked;
`ifdef CMD_DISPATCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
  logic                   tmo_q, tmo_d;
`endif

  assign capture  = cmd_ready && !cmd_ready_q;
  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;
  assign opc      = head[OPC_MSB:OPC_LSB];
  assign sel      = opc[SEL_MSB:SEL_LSB];
  // unit_valid is one-hot on the selected unit, so masking ack with it ignores other units.
  assign acked    = |(unit_ack & unit_valid_q);

  cmd_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .din   (cmd_in),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d      = state_q;
    unit_valid_d = unit_valid_q;
    payload_d    = payload_q;
    bad_d        = bad_q;
    overflow_d   = overflow_q || (capture && fifo_full && !fifo_pop);
`ifdef CMD_DISPATCH_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    tmo_d        = tmo_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (!opc_class_ok(opc, OPC_VALID_MASK) || (int'(sel) >= NUM_UNITS)) begin
          bad_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          for (int unsigned u = 0; u < NUM_UNITS; u++) unit_valid_d[u] = (u == int'(sel));
          payload_d = head[PAYLOAD_W-1:0];
          state_d   = ST_WAIT_ACK;
`ifdef CMD_DISPATCH_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end
      ST_WAIT_ACK: begin
        if (acked) begin
          unit_valid_d = '0;
          state_d      = ST_IDLE;
        end
`ifdef CMD_DISPATCH_TIMEOUT_EN
        else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          unit_valid_d = '0;
          tmo_d        = 1'b1;
          state_d      = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b0;
      unit_valid_q <= '0;
      payload_q    <= '0;
      overflow_q   <= 1'b0;
      bad_q        <= 1'b0;
`ifdef CMD_DISPATCH_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      tmo_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_ready_q  <= cmd_ready;
      unit_valid_q <= unit_valid_d;
      payload_q    <= payload_d;
      overflow_q   <= overflow_d;
      bad_q        <= bad_d;
`ifdef CMD_DISPATCH_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      tmo_q        <= tmo_d;
`endif
    end
  end

  assign unit_valid   = unit_valid_q;
  assign unit_payload = payload_q;
  assign overflow     = overflow_q;
  assign bad_opcode   = bad_q;
  assign idle         = fifo_empty && (state_q == ST_IDLE);
`ifdef CMD_DISPATCH_TIMEOUT_EN
  assign ack_timeout  = tmo_q;
`endif

endmodule

// File: tb/tb_cmd_dispatcher.sv
module tb_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cmd_in;
  logic        cmd_ready;
  logic [3:0]  unit_valid;
  logic [55:0] unit_payload;
  logic [3:0]  unit_ack;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        bad_opcode;
  logic        idle;
`ifdef CMD_DISPATCH_TIMEOUT_EN
  logic        ack_timeout;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cmd_dispatcher #(
    .NUM_UNITS(4),
    .FIFO_DEPTH(4),
    .OPC_VALID_MASK(8'hF0),
    .TIMEOUT(10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_in       (cmd_in),
    .cmd_ready    (cmd_ready),
    .unit_valid   (unit_valid),
    .unit_payload (unit_payload),
    .unit_ack     (unit_ack),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .bad_opcode   (bad_opcode),
    .idle         (idle)
`ifdef CMD_DISPATCH_TIMEOUT_EN
    ,
    .ack_timeout  (ack_timeout)
`endif
  );

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cmd_ready = 1'b0; unit_ack = '0; cmd_in = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // One capture: ready high for one edge, then low for one edge.
  task automatic send_cmd(input logic [63:0] c);
    cmd_in = c; cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    tick();
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (unit_valid != '0) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (unit_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", unit_valid); end
    checks++; if (unit_payload !== 56'h0) begin errors++; $display("FAIL reset_payload: got %h expected 0", unit_payload); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if ({overflow, bad_opcode, idle} !== 3'b001) begin errors++; $display("FAIL reset_flags: got ovf/bad/idle=%b expected 001", {overflow, bad_opcode, idle}); end
  endtask

  task automatic test_single();
    cmd_in = 64'hF1_00000000_00ABCD; cmd_ready = 1'b1;
    tick();
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL single_push_level: got %0d expected 1", fifo_level); end
    tick();
    checks++; if (unit_valid !== 4'b0000) begin errors++; $display("FAIL single_early_valid: got %b expected 0000", unit_valid); end
    tick();
    checks++; if (unit_valid !== 4'b0010) begin errors++; $display("FAIL single_valid: got %b expected 0010", unit_valid); end
    checks++; if (unit_payload !== 56'h00000000_00ABCD) begin errors++; $display("FAIL single_payload: got %h expected 0000000000abcd", unit_payload); end
    tick(); tick();
    cmd_ready = 1'b0;
    checks++; if (unit_valid !== 4'b0010) begin errors++; $display("FAIL single_hold: got %b expected 0010", unit_valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL single_one_push: got level %0d expected 0", fifo_level); end
    unit_ack = 4'b0010;
    tick();
    unit_ack = '0;
    checks++; if (unit_valid !== 4'b0000) begin errors++; $display("FAIL single_drop: got %b expected 0000", unit_valid); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle: got %b expected 1", idle); end
    tick(); tick(); tick();
    checks++; if (unit_valid !== 4'b0000) begin errors++; $display("FAIL single_no_redispatch: got %b expected 0000", unit_valid); end
  endtask

  task automatic test_illegal();
    send_cmd(64'h31_00000000_000001);
    tick();
    checks++; if (unit_valid !== 4'b0000) begin errors++; $display("FAIL illegal_valid: got %b expected 0000", unit_valid); end
    checks++; if (bad_opcode !== 1'b1) begin errors++; $display("FAIL illegal_bad: got %b expected 1", bad_opcode); end
    send_cmd(64'hF2_00000000_001234);
    tick();
    checks++; if (unit_valid !== 4'b0100) begin errors++; $display("FAIL illegal_next_valid: got %b expected 0100", unit_valid); end
    checks++; if (unit_payload !== 56'h1234) begin errors++; $display("FAIL illegal_next_payload: got %h expected 1234", unit_payload); end
    checks++; if (bad_opcode !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got %b expected 1", bad_opcode); end
    unit_ack = 4'b0100; tick(); unit_ack = '0;
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset();
    for (int k = 0; k < 6; k++) send_cmd({8'hF0 | 8'(k % 4), 56'hA0 + 56'(k)});
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", fifo_level); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    for (int k = 0; k < 5; k++) begin
      wait_valid(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL ovf_wait_%0d: got no unit_valid expected dispatch within 10 cycles", k); end
      else if (unit_valid !== 4'(1 << (k % 4)) || unit_payload !== 56'hA0 + 56'(k)) begin
        errors++;
        $display("FAIL ovf_order_%0d: got valid=%b payload=%h expected valid=%b payload=%h",
                 k, unit_valid, unit_payload, 4'(1 << (k % 4)), 56'hA0 + 56'(k));
      end
      unit_ack = unit_valid; tick(); unit_ack = '0;
    end
    tick(); tick(); tick(); tick();
    checks++; if (unit_valid !== 4'b0000 || idle !== 1'b1) begin errors++; $display("FAIL ovf_sixth_lost: got valid=%b idle=%b expected 0000 1", unit_valid, idle); end
  endtask

  task automatic test_push_pop_full();
    do_reset();
    send_cmd(64'hF0_00000000_000010);
    for (int k = 1; k < 5; k++) send_cmd({8'hF1, 56'h10 + 56'(k)});
    checks++; if (fifo_level !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL pp_fill: got level=%0d ovf=%b expected 4 0", fifo_level, overflow); end
    unit_ack = 4'b0001; tick(); unit_ack = '0;
    cmd_in = 64'hF3_00000000_000099; cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL pp_level: got %0d expected 4", fifo_level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL pp_overflow: got %b expected 0", overflow); end
    tick();
    checks++; if (unit_valid !== 4'b0010 || unit_payload !== 56'h11) begin errors++; $display("FAIL pp_next: got valid=%b payload=%h expected 0010 11", unit_valid, unit_payload); end
  endtask

  task automatic test_wrong_unit();
    do_reset();
    send_cmd(64'hF2_00000000_000077);
    tick();
    checks++; if (unit_valid !== 4'b0100) begin errors++; $display("FAIL wu_valid: got %b expected 0100", unit_valid); end
    unit_ack = 4'b0001; tick();
    unit_ack = 4'b1011; tick(); unit_ack = '0;
    checks++; if (unit_valid !== 4'b0100 || unit_payload !== 56'h77) begin errors++; $display("FAIL wu_ignored: got valid=%b payload=%h expected 0100 77", unit_valid, unit_payload); end
    unit_ack = 4'b0100; tick(); unit_ack = '0;
    checks++; if (unit_valid !== 4'b0000 || idle !== 1'b1) begin errors++; $display("FAIL wu_complete: got valid=%b idle=%b expected 0000 1", unit_valid, idle); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_cmd(64'hF3_00000000_000005);
    send_cmd(64'hF0_00000000_000006);
    send_cmd(64'hF1_00000000_000007);
    checks++; if (unit_valid !== 4'b1000 || fifo_level !== 3'd2) begin errors++; $display("FAIL rm_setup: got valid=%b level=%0d expected 1000 2", unit_valid, fifo_level); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (unit_valid !== 4'b0000 || fifo_level !== 3'd0 || idle !== 1'b1) begin
      errors++; $display("FAIL rm_state: got valid=%b level=%0d idle=%b expected 0000 0 1", unit_valid, fifo_level, idle);
    end
    tick(); tick(); tick();
    checks++; if (unit_valid !== 4'b0000) begin errors++; $display("FAIL rm_lost: got %b expected 0000", unit_valid); end
  endtask

`ifdef CMD_DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    send_cmd(64'hF1_00000000_000042);
    tick();
    repeat (9) tick();
    checks++; if (ack_timeout !== 1'b0 || unit_valid !== 4'b0010) begin errors++; $display("FAIL to_early: got tmo=%b valid=%b expected 0 0010", ack_timeout, unit_valid); end
    tick();
    checks++; if (ack_timeout !== 1'b1 || unit_valid !== 4'b0000) begin errors++; $display("FAIL to_fire: got tmo=%b valid=%b expected 1 0000", ack_timeout, unit_valid); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_illegal();
    test_overflow();
    test_push_pop_full();
    test_wrong_unit();
    test_reset_mid();
`ifdef CMD_DISPATCH_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_dispatcher.md
Name: cmd_dispatcher

Overview:
Sits downstream of the 8-byte parallel command receiver. Captures each assembled 64-bit command once per receiver ready assertion and queues it in a small FIFO. Decodes the opcode byte and hands the payload to one of NUM_UNITS execution units over a valid/ack handshake, one command in flight at a time. Provides overflow and bad-opcode status for the host.

Parameters:
NUM_UNITS, 4, number of execution units; opcode[1:0] selects the unit; must be ≤4.
FIFO_DEPTH, 4, command queue depth; power of two, ≥2.
OPC_VALID_MASK, 8'hF0, opcode[7:4] must equal this mask's upper nibble, else the command is illegal.
TIMEOUT, 255, ack watchdog limit in cycles; used only with the optional feature.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
cmd_in  in  64  assembled command; opcode = cmd_in[63:56], payload = cmd_in[55:0].
cmd_ready  in  1  receiver ready; level, may stay high for many cycles per command.
unit_valid  out  NUM_UNITS  one-hot request to the selected unit.
unit_payload  out  56  payload of the in-flight command.
unit_ack  in  NUM_UNITS  unit accepts the command; only the selected bit is honoured.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current queue occupancy.
overflow  out  1  sticky; set when a capture is lost to a full FIFO.
bad_opcode  out  1  sticky; set when an illegal opcode is dropped.
idle  out  1  high when the FIFO is empty and the FSM is in IDLE.

Behaviour:
- Reset (synchronous): FIFO empty, FSM to IDLE, unit_valid=0, unit_payload=0, overflow=0, bad_opcode=0, fifo_level=0, idle=1. The edge-detect register is cleared to 0.
- Capture: register cmd_ready_d; capture_pulse = cmd_ready & ~cmd_ready_d. Push cmd_in on capture_pulse only. A ready held high for N cycles yields exactly one push.
- Push when full: command discarded, overflow set, no other state change.
- Same-cycle push and pop: both occur; level unchanged. Push on a full FIFO with a pop in the same cycle is accepted and does not set overflow.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head (registered read). Go to DECODE.
  - DECODE: if opcode[7:4] != OPC_VALID_MASK[7:4], or opcode[1:0] ≥ NUM_UNITS, set bad_opcode and go to IDLE. Otherwise drive unit_valid[opcode[1:0]]=1 and unit_payload, then go to WAIT_ACK.
  - WAIT_ACK: hold unit_valid and unit_payload stable. When unit_ack[sel]=1, drop unit_valid on the next edge and go to IDLE. Ack bits for non-selected units are ignored.
- Latency: capture edge to unit_valid high is 3 cycles with the FIFO empty and the FSM idle (push, IDLE/pop, DECODE→valid).
- Throughput: one command per 3 cycles minimum. unit_valid is low for at least 1 cycle between commands.
- unit_valid is never asserted on more than one bit.
- Reset mid-handshake: unit_valid drops on the reset edge; the in-flight command and the queued commands are lost.
- fifo_level wraps correctly at pointer wrap; pointers are one bit wider than the address.

Optional Feature:
CMD_DISPATCH_TIMEOUT_EN
- Defined: WAIT_ACK has a counter cleared on entry. If it reaches TIMEOUT without an ack, drop unit_valid, set sticky output ack_timeout (1 bit, reset 0) and return to IDLE. The command is discarded.
- Undefined: no counter and no ack_timeout port; WAIT_ACK waits indefinitely.

Decomposition:
- Shared package cmd_pkg holds:
  - OPC_MSB=63, OPC_LSB=56, PAYLOAD_W=56, CMD_W=64.
  - FSM state encodings: IDLE=0, DECODE=1, WAIT_ACK=2.
  - Unit-select field bits [1:0].
- One sub-module, cmd_fifo: synchronous FIFO with parameters WIDTH and DEPTH, signals push/pop/full/empty/level, and a registered dout.
- Edge detect, decode and FSM stay in cmd_dispatcher.

Test Plan:
- Single command: cmd_ready high 5 cycles, cmd_in=64'hF1_00000000_00ABCD → exactly one push; unit_valid=4'b0010 3 cycles after the edge, payload 56'h00000000_00ABCD. ack 2 cycles later → valid drops next edge, idle=1.
- Illegal opcode: opcode 8'h31 → no unit_valid, bad_opcode=1 and stays set; the next legal command still dispatches.
- Overflow: hold unit_ack=0 and send 6 commands (FIFO_DEPTH=4, 1 in flight) → fifo_level=4, overflow=1. Release ack → 5 commands dispatched in order.
- Simultaneous push/pop at full: FIFO full, capture edge coincident with an IDLE pop → level stays 4, overflow stays 0.
- Wrong-unit ack: unit 2 selected, pulse unit_ack[0] → no effect; assert unit_ack[2] → completes.
- Reset in WAIT_ACK with 2 queued → next cycle unit_valid=0, fifo_level=0, idle=1. With CMD_DISPATCH_TIMEOUT_EN and TIMEOUT=10, no ack → ack_timeout=1 at cycle 10 of WAIT_ACK.
